reco_dot_acc: RTL

Streaming dot-product accumulator for the Axiline recommender inference datapath. It multiplies paired user/item feature elements, accumulates `size` products into one prediction, and presents the result to the downstream combinational error/scale stage (`data_out*rate - bias`) through a valid/ready handshake. It sits directly upstream of that stage. Its `data_out` width matches that stage's `data_in` width (`bitwidth`).

---
 rtl/reco_dot_acc.sv | 92 +++++++++
 1 files changed

// File: rtl/reco_dot_acc.sv
`default_nettype none
// ---------------------------------------------------------------------------
// reco_dot_acc : streaming unsigned dot-product accumulator, valid/ready out
// Revision 1.0
// ---------------------------------------------------------------------------
module reco_dot_acc #(
   parameter int bitwidth      = 32,
   parameter int inputBitwidth = 16,
   parameter int size          = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic                     in_valid,
   input  logic [inputBitwidth-1:0] a_in,
   input  logic [inputBitwidth-1:0] b_in,
   output logic                     in_ready,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [bitwidth-1:0]      data_out,
   output logic                     busy
);

   localparam int CNT_W = (size > 1) ? $clog2(size) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(size - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                       state;
   logic [CNT_W-1:0]             cnt;
   logic [2*inputBitwidth-1:0]   prod;
   logic [bitwidth-1:0]          prod_ext;

   // Size cast zero-extends or truncates to the accumulator width.
   assign prod     = a_in * b_in;
   assign prod_ext = bitwidth'(prod);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         data_out  <= '0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  data_out <= '0;
                  cnt      <= '0;
                  state    <= S_ACC;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            S_ACC: begin
               if (in_valid) begin
                  data_out <= data_out + prod_ext;
                  if (cnt == LAST) begin
                     cnt       <= '0;
                     state     <= S_DONE;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  state     <= S_IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
               end
            end
            default: begin
               state     <= S_IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire
